// File: rtl/controller_fsm.sv
// Microcoded control decode for the 16-bit single-bus multicycle CPU.
// The state register lives in the datapath; only the JZ zero flag is held here.
module controller_fsm (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] IR,
    input  logic        z,
    input  logic [4:0]  state,
    output logic [4:0]  nextstate,
    output logic [2:0]  fnSel,
    output logic        ldMAR,
    output logic        ldIR,
    output logic        ldPC,
    output logic        ldSP,
    output logic        ldMDR,
    output logic        ldReg,
    output logic        ldRegBank,
    output logic        TReg,
    output logic        TRegBank,
    output logic        TSP,
    output logic        TMAR,
    output logic        TPC,
    output logic        TMDR,
    output logic        TLabel,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite
);

    typedef enum logic [4:0] {
        S_FETCH0    = 5'd0,
        S_FETCH1    = 5'd1,
        S_FETCH2    = 5'd2,
        S_DECODE    = 5'd3,
        S_ALU_A     = 5'd4,
        S_ALU_B     = 5'd5,
        S_ALU_WB    = 5'd6,
        S_LD_A      = 5'd7,
        S_LD_B      = 5'd8,
        S_LD_ADDR   = 5'd9,
        S_LD_MEM    = 5'd10,
        S_LD_WB     = 5'd11,
        S_ST_ADDR   = 5'd12,
        S_ST_DATA   = 5'd13,
        S_ST_MEM    = 5'd14,
        S_MOV       = 5'd15,
        S_JMP       = 5'd16,
        S_PUSH_DEC  = 5'd17,
        S_PUSH_SP   = 5'd18,
        S_PUSH_DATA = 5'd19,
        S_PUSH_MEM  = 5'd20,
        S_POP_ADDR  = 5'd21,
        S_POP_MEM   = 5'd22,
        S_POP_WB    = 5'd23,
        S_POP_SP    = 5'd24,
        S_HALT      = 5'd25
    } state_e;

    typedef enum logic [2:0] {
        FN_ADD  = 3'b000,
        FN_SUB  = 3'b001,
        FN_AND  = 3'b010,
        FN_OR   = 3'b011,
        FN_XOR  = 3'b100,
        FN_PASS = 3'b101,
        FN_INC  = 3'b110,
        FN_DEC  = 3'b111
    } fn_e;

    state_e     cur_state;
    state_e     next_state;
    state_e     dispatch_state;
    fn_e        fn;
    logic [3:0] opcode;
    logic       z_d;
    logic       z_q;
    logic       unused_ir;

    assign cur_state = state_e'(state);
    assign opcode    = IR[15:12];
    assign unused_ir = ^IR[11:0];
    assign nextstate = next_state;
    assign fnSel     = fn;

    // Zero flag is captured only while the ALU operate step is on the bus.
    always_comb begin
        z_d = z_q;
        if (cur_state == S_ALU_B) begin
            z_d = z;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            z_q <= 1'b0;
        end else begin
            z_q <= z_d;
        end
    end

    always_comb begin
        dispatch_state = S_FETCH0;
        case (opcode)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: dispatch_state = S_ALU_A;
            4'h5, 4'h6, 4'h7:             dispatch_state = S_FETCH0;
            4'h8:                         dispatch_state = S_LD_A;
            4'h9:                         dispatch_state = S_ST_ADDR;
            4'hA:                         dispatch_state = S_MOV;
            4'hB:                         dispatch_state = S_JMP;
            4'hC:                         dispatch_state = z_q ? S_JMP : S_FETCH0;
            4'hD:                         dispatch_state = S_PUSH_DEC;
            4'hE:                         dispatch_state = S_POP_ADDR;
            4'hF:                         dispatch_state = S_HALT;
            default:                      dispatch_state = S_FETCH0;
        endcase
    end

    always_comb begin
        next_state = S_FETCH0;
        fn         = FN_ADD;
        ldMAR      = 1'b0;
        ldIR       = 1'b0;
        ldPC       = 1'b0;
        ldSP       = 1'b0;
        ldMDR      = 1'b0;
        ldReg      = 1'b0;
        ldRegBank  = 1'b0;
        TReg       = 1'b0;
        TRegBank   = 1'b0;
        TSP        = 1'b0;
        TMAR       = 1'b0;
        TPC        = 1'b0;
        TMDR       = 1'b0;
        TLabel     = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        // Reset forces the idle decode without waiting for the external state register.
        if (!Reset) begin
            case (cur_state)
                S_FETCH0: begin
                    TPC = 1'b1; ldMAR = 1'b1; fn = FN_INC; ldReg = 1'b1;
                    next_state = S_FETCH1;
                end
                S_FETCH1: begin
                    MemRead = 1'b1; ldMDR = 1'b1;
                    next_state = S_FETCH2;
                end
                S_FETCH2: begin
                    TMDR = 1'b1; ldIR = 1'b1; IRWrite = 1'b1;
                    next_state = S_DECODE;
                end
                S_DECODE: begin
                    TReg = 1'b1; ldPC = 1'b1;
                    next_state = dispatch_state;
                end
                S_ALU_A: begin
                    TRegBank = 1'b1; fn = FN_PASS; ldReg = 1'b1;
                    next_state = S_ALU_B;
                end
                S_ALU_B: begin
                    TLabel = 1'b1; fn = fn_e'(IR[14:12]); ldReg = 1'b1;
                    next_state = S_ALU_WB;
                end
                S_ALU_WB: begin
                    TReg = 1'b1; ldRegBank = 1'b1;
                    next_state = S_FETCH0;
                end
                S_LD_A: begin
                    TRegBank = 1'b1; fn = FN_PASS; ldReg = 1'b1;
                    next_state = S_LD_B;
                end
                S_LD_B: begin
                    TLabel = 1'b1; fn = FN_ADD; ldReg = 1'b1;
                    next_state = S_LD_ADDR;
                end
                S_LD_ADDR: begin
                    TReg = 1'b1; ldMAR = 1'b1;
                    next_state = S_LD_MEM;
                end
                S_LD_MEM: begin
                    MemRead = 1'b1; ldMDR = 1'b1;
                    next_state = S_LD_WB;
                end
                S_LD_WB: begin
                    TMDR = 1'b1; ldRegBank = 1'b1;
                    next_state = S_FETCH0;
                end
                S_ST_ADDR: begin
                    TLabel = 1'b1; ldMAR = 1'b1;
                    next_state = S_ST_DATA;
                end
                S_ST_DATA: begin
                    TRegBank = 1'b1; ldMDR = 1'b1;
                    next_state = S_ST_MEM;
                end
                S_ST_MEM: begin
                    MemWrite = 1'b1;
                    next_state = S_FETCH0;
                end
                S_MOV: begin
                    TLabel = 1'b1; ldRegBank = 1'b1;
                    next_state = S_FETCH0;
                end
                S_JMP: begin
                    TLabel = 1'b1; ldPC = 1'b1;
                    next_state = S_FETCH0;
                end
                S_PUSH_DEC: begin
                    TSP = 1'b1; fn = FN_DEC; ldReg = 1'b1;
                    next_state = S_PUSH_SP;
                end
                S_PUSH_SP: begin
                    TReg = 1'b1; ldSP = 1'b1; ldMAR = 1'b1;
                    next_state = S_PUSH_DATA;
                end
                S_PUSH_DATA: begin
                    TRegBank = 1'b1; ldMDR = 1'b1;
                    next_state = S_PUSH_MEM;
                end
                S_PUSH_MEM: begin
                    MemWrite = 1'b1;
                    next_state = S_FETCH0;
                end
                S_POP_ADDR: begin
                    TSP = 1'b1; ldMAR = 1'b1; fn = FN_INC; ldReg = 1'b1;
                    next_state = S_POP_MEM;
                end
                S_POP_MEM: begin
                    MemRead = 1'b1; ldMDR = 1'b1;
                    next_state = S_POP_WB;
                end
                S_POP_WB: begin
                    TMDR = 1'b1; ldRegBank = 1'b1;
                    next_state = S_POP_SP;
                end
                S_POP_SP: begin
                    TReg = 1'b1; ldSP = 1'b1;
                    next_state = S_FETCH0;
                end
                S_HALT: begin
                    next_state = S_HALT;
                end
                default: begin
                    next_state = S_FETCH0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controller_fsm.sv
// Scoreboard bench for controller_fsm: a table-driven microcode model predicts each
// cycle's decode, a monitor compares on the falling edge.
module tb_controller_fsm;

    logic        Clk;
    logic        Reset;
    logic [15:0] IR;
    logic        z;
    logic [4:0]  state;
    logic [4:0]  nextstate;
    logic [2:0]  fnSel;
    logic ldMAR, ldIR, ldPC, ldSP, ldMDR, ldReg, ldRegBank;
    logic TReg, TRegBank, TSP, TMAR, TPC, TMDR, TLabel;
    logic MemRead, MemWrite, IRWrite;

    controller_fsm dut (
        .Clk(Clk), .Reset(Reset), .IR(IR), .z(z), .state(state),
        .nextstate(nextstate), .fnSel(fnSel),
        .ldMAR(ldMAR), .ldIR(ldIR), .ldPC(ldPC), .ldSP(ldSP), .ldMDR(ldMDR),
        .ldReg(ldReg), .ldRegBank(ldRegBank),
        .TReg(TReg), .TRegBank(TRegBank), .TSP(TSP), .TMAR(TMAR), .TPC(TPC),
        .TMDR(TMDR), .TLabel(TLabel),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0]  ns;
        logic [2:0]  fn;
        logic [16:0] ctl;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];
    int    checks   = 0;
    int    failures = 0;

    // Bit i of a control vector corresponds to sig_names[i].
    string sig_names [17] = '{"ldMAR", "ldIR", "ldPC", "ldSP", "ldMDR", "ldReg", "ldRegBank",
                              "TReg", "TRegBank", "TSP", "TMAR", "TPC", "TMDR", "TLabel",
                              "MemRead", "MemWrite", "IRWrite"};
    string ctl_tab [32];
    int    fn_tab  [32];
    int    nx_tab  [32];

    logic       mzq;
    logic       prev_rst;
    logic [4:0] prev_state;
    logic       prev_z;

    function automatic void put(int s, string c, int f, int n);
        ctl_tab[s] = c;
        fn_tab[s]  = f;
        nx_tab[s]  = n;
    endfunction

    // fn -1: taken from IR[14:12]; next -1: opcode dispatch.
    function automatic void init_tables();
        for (int s = 0; s < 32; s++) put(s, "", 0, 0);
        put(0,  "TPC ldMAR ldReg",   6, 1);
        put(1,  "MemRead ldMDR",     0, 2);
        put(2,  "TMDR ldIR IRWrite", 0, 3);
        put(3,  "TReg ldPC",         0, -1);
        put(4,  "TRegBank ldReg",    5, 5);
        put(5,  "TLabel ldReg",     -1, 6);
        put(6,  "TReg ldRegBank",    0, 0);
        put(7,  "TRegBank ldReg",    5, 8);
        put(8,  "TLabel ldReg",      0, 9);
        put(9,  "TReg ldMAR",        0, 10);
        put(10, "MemRead ldMDR",     0, 11);
        put(11, "TMDR ldRegBank",    0, 0);
        put(12, "TLabel ldMAR",      0, 13);
        put(13, "TRegBank ldMDR",    0, 14);
        put(14, "MemWrite",          0, 0);
        put(15, "TLabel ldRegBank",  0, 0);
        put(16, "TLabel ldPC",       0, 0);
        put(17, "TSP ldReg",         7, 18);
        put(18, "TReg ldSP ldMAR",   0, 19);
        put(19, "TRegBank ldMDR",    0, 20);
        put(20, "MemWrite",          0, 0);
        put(21, "TSP ldMAR ldReg",   6, 22);
        put(22, "MemRead ldMDR",     0, 23);
        put(23, "TMDR ldRegBank",    0, 24);
        put(24, "TReg ldSP",         0, 0);
        put(25, "",                  0, 25);
    endfunction

    function automatic logic [16:0] mask_of(string s);
        logic [16:0] m;
        string p;
        string w;
        m = '0;
        p = {" ", s, " "};
        for (int i = 0; i < 17; i++) begin
            w = {" ", sig_names[i], " "};
            for (int k = 0; k + w.len() <= p.len(); k++)
                if (p.substr(k, k + w.len() - 1) == w) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic int dispatch_of(logic [3:0] op, logic zq);
        int o;
        o = int'(op);
        if (o <= 4) return 4;
        if (o <= 7) return 0;
        case (o)
            8:       return 7;
            9:       return 12;
            10:      return 15;
            11:      return 16;
            12:      return zq ? 16 : 0;
            13:      return 17;
            14:      return 21;
            default: return 25;
        endcase
    endfunction

    function automatic exp_t model(logic r, logic [4:0] st, logic [15:0] ir, logic zq);
        exp_t e;
        int   s;
        e = '0;
        if (r) return e;
        s = int'(st);
        e.ctl = mask_of(ctl_tab[s]);
        e.fn  = (fn_tab[s] < 0) ? ir[14:12] : 3'(fn_tab[s]);
        e.ns  = (nx_tab[s] < 0) ? 5'(dispatch_of(ir[15:12], zq)) : 5'(nx_tab[s]);
        return e;
    endfunction

    task automatic step(input logic r, input logic [4:0] st, input logic [15:0] ir,
                        input logic zz, input string tag, output logic [4:0] nxt);
        exp_t e;
        @(posedge Clk);
        if (!prev_rst && prev_state == 5'd5) mzq = prev_z;
        #1;
        Reset = r;
        state = st;
        IR    = ir;
        z     = zz;
        if (r) mzq = 1'b0;
        e = model(r, st, ir, mzq);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        prev_rst   = r;
        prev_state = st;
        prev_z     = zz;
        nxt        = e.ns;
    endtask

    task automatic one(input logic r, input logic [4:0] st, input logic [15:0] ir,
                       input logic zz, input string tag);
        logic [4:0] dummy;
        step(r, st, ir, zz, tag, dummy);
    endtask

    // Follow the predicted state sequence of one instruction starting at fetch.
    task automatic walk(input logic [15:0] ir, input logic zz, input string tag);
        logic [4:0] st;
        logic [4:0] nxt;
        int         halts;
        st    = 5'd0;
        halts = 0;
        for (int n = 0; n < 16; n++) begin
            step(1'b0, st, ir, zz, $sformatf("%s_s%0d", tag, st), nxt);
            if (st == 5'd25) halts++;
            if (nxt == 5'd0 || halts >= 3) break;
            st = nxt;
        end
    endtask

    exp_t        mon_e;
    string       mon_t;
    logic [16:0] mon_act;
    logic [6:0]  mon_tbits;

    initial begin
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                mon_e   = exp_q.pop_front();
                mon_t   = tag_q.pop_front();
                mon_act = {IRWrite, MemWrite, MemRead, TLabel, TMDR, TPC, TMAR, TSP,
                           TRegBank, TReg, ldRegBank, ldReg, ldMDR, ldSP, ldPC, ldIR, ldMAR};
                mon_tbits = mon_act[13:7];
                checks++;
                if (nextstate !== mon_e.ns) begin
                    failures++;
                    $display("FAIL %s nextstate got %0d expected %0d", mon_t, nextstate, mon_e.ns);
                end
                checks++;
                if (fnSel !== mon_e.fn) begin
                    failures++;
                    $display("FAIL %s fnSel got %b expected %b", mon_t, fnSel, mon_e.fn);
                end
                checks++;
                if (mon_act !== mon_e.ctl) begin
                    failures++;
                    $display("FAIL %s controls got %b expected %b", mon_t, mon_act, mon_e.ctl);
                end
                checks++;
                if ($countones(mon_tbits) > 1) begin
                    failures++;
                    $display("FAIL %s bus_drivers got %b expected at most one set", mon_t, mon_tbits);
                end
            end
        end
    end

    initial begin
        logic [15:0] rir;
        init_tables();
        Reset      = 1'b0;
        state      = '0;
        IR         = '0;
        z          = 1'b0;
        mzq        = 1'b0;
        prev_rst   = 1'b1;
        prev_state = '0;
        prev_z     = 1'b0;

        one(1'b1, 5'd0, 16'h0000, 1'b0, "reset_s0");
        one(1'b1, 5'd3, 16'hC000, 1'b1, "reset_s3");
        one(1'b1, 5'd5, 16'h1000, 1'b1, "reset_s5");

        walk(16'h0000, 1'b0, "alu_add");
        one(1'b0, 5'd0, 16'h000F, 1'b0, "fetch0");
        one(1'b0, 5'd2, 16'h000F, 1'b0, "fetch2");
        one(1'b0, 5'd5, 16'h1000, 1'b0, "sub_fn");
        one(1'b0, 5'd3, 16'hC000, 1'b0, "jz_not_taken");
        walk(16'h0000, 1'b1, "alu_zero");
        one(1'b0, 5'd3, 16'hC000, 1'b0, "jz_taken");
        walk(16'hC123, 1'b0, "jz_walk");
        walk(16'hF000, 1'b0, "halt");
        one(1'b1, 5'd25, 16'hF000, 1'b0, "halt_reset");
        one(1'b0, 5'd3, 16'hC000, 1'b0, "zq_cleared");
        one(1'b0, 5'd27, 16'h0000, 1'b0, "illegal27");
        one(1'b0, 5'd31, 16'hFFFF, 1'b1, "illegal31");
        one(1'b0, 5'd3, 16'h6000, 1'b0, "reserved6");
        walk(16'hD1C0, 1'b0, "push");
        walk(16'hE200, 1'b0, "pop");
        walk(16'h8A45, 1'b0, "load");
        walk(16'h9185, 1'b0, "store");
        walk(16'hA7FF, 1'b0, "mov");
        walk(16'hB010, 1'b0, "jmp");
        for (int op = 0; op < 5; op++) begin
            rir = 16'($urandom);
            rir[15:12] = 4'(op);
            walk(rir, 1'($urandom), $sformatf("alu_op%0d", op));
        end

        for (int n = 0; n < 40; n++) begin
            walk(16'($urandom), 1'($urandom), $sformatf("rwalk%0d", n));
            if ((n % 8) == 7) one(1'b1, 5'($urandom), 16'($urandom), 1'($urandom), "rwalk_reset");
        end
        for (int n = 0; n < 300; n++) begin
            one(1'($urandom_range(0, 15) == 0), 5'($urandom), 16'($urandom), 1'($urandom),
                $sformatf("rand%0d", n));
        end

        repeat (3) @(posedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending got %0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
